vga_scanout: RTL and testbench

Parametrised VGA timing generator and framebuffer scanout engine. It generates a configurable video timing and streams 16-bit words from a synchronous VRAM read port. Words are unpacked into 4:4:4 RGB in either 1 bpp monochrome (Hack screen format) or 8 bpp 2:2:2 colour. The frame base address and pixel mode are latched per frame, which enables page flipping. It sits between the VRAM read port and the board VGA pins, on the same pixel clock enable as the rest of the display path.

---
 rtl/vga_scanout_if.sv | 10 +
 rtl/vga_scanout.sv | 144 ++++++++++++++
 tb/tb_vga_scanout.sv | 310 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vga_scanout_if.sv
// VRAM read port between the scanout engine (master) and a synchronous VRAM (slave).
interface vga_scanout_if #(
    parameter int ADDR_W = 18
);
    logic [ADDR_W-1:0] vram_raddr;
    logic [15:0]       vram_rdata;

    modport master (output vram_raddr, input vram_rdata);
    modport slave  (input vram_raddr, output vram_rdata);
endinterface

// File: rtl/vga_scanout.sv
// VGA timing generator and framebuffer scanout: fetches 16-bit VRAM words and
// unpacks them to 4:4:4 RGB as 1 bpp mono or 8 bpp 2:2:2 colour.
module vga_scanout #(
    parameter int ADDR_W       = 18,
    parameter int H_ACTIVE     = 640,
    parameter int H_FP         = 16,
    parameter int H_SYNC       = 96,
    parameter int H_BP         = 48,
    parameter int V_ACTIVE     = 480,
    parameter int V_FP         = 10,
    parameter int V_SYNC       = 2,
    parameter int V_BP         = 33,
    parameter bit SYNC_POL     = 1'b0,
    parameter int READ_LATENCY = 1
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              clken,
    input  logic              mode,
    input  logic [ADDR_W-1:0] base_addr,
    vga_scanout_if.master     vram,
    output logic              h_sync,
    output logic              v_sync,
    output logic [3:0]        red,
    output logic [3:0]        green,
    output logic [3:0]        blue,
    output logic              vblank,
    output logic              frame_start
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);
    localparam int RL      = READ_LATENCY;

    logic [HW-1:0]     hc_q;
    logic [VW-1:0]     vc_q;
    logic              mode_q;
    logic [ADDR_W-1:0] ptr_q;
    logic [ADDR_W-1:0] raddr_q;
    logic [RL:0]       act_pipe_q;
    logic [RL:0]       hs_pipe_q;
    logic [RL:0]       vs_pipe_q;
    logic [RL-1:0]     ld_pipe_q;
    logic [15:0]       sh_q, sh_d;
    logic [11:0]       rgb_q, rgb_d;
    logic              hs_q, vs_q, fs_q;

    logic h_end, v_end, wrap, act_c, hs_c, vs_c, fetch_c;

    // Counter-stage decode; everything below is a delayed copy of these.
    assign h_end   = (hc_q == HW'(H_TOTAL - 1));
    assign v_end   = (vc_q == VW'(V_TOTAL - 1));
    assign wrap    = h_end && v_end;
    assign act_c   = (hc_q < HW'(H_ACTIVE)) && (vc_q < VW'(V_ACTIVE));
    assign hs_c    = (hc_q >= HW'(H_ACTIVE + H_FP)) && (hc_q < HW'(H_ACTIVE + H_FP + H_SYNC));
    assign vs_c    = (vc_q >= VW'(V_ACTIVE + V_FP)) && (vc_q < VW'(V_ACTIVE + V_FP + V_SYNC));
    assign fetch_c = act_c && (mode_q ? (hc_q[0] == 1'b0) : (hc_q[3:0] == 4'd0));

    // The word arrives exactly when its first pixel is due, so it replaces the
    // shifter contents; otherwise the next pixel moves to the front.
    always_comb begin
        sh_d = sh_q;
        if (ld_pipe_q[RL-1])
            sh_d = vram.vram_rdata;
        else if (mode_q)
            sh_d = {sh_q[7:0], 8'h00};
        else
            sh_d = {1'b0, sh_q[15:1]};
    end

    always_comb begin
        rgb_d = 12'h000;
        if (act_pipe_q[RL]) begin
            if (mode_q)
                rgb_d = {sh_q[13:12], sh_q[13:12], sh_q[11:10], sh_q[11:10], sh_q[9:8], sh_q[9:8]};
            else
                rgb_d = {12{~sh_q[0]}};
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            hc_q       <= HW'(H_TOTAL - 1);
            vc_q       <= VW'(V_TOTAL - 1);
            mode_q     <= 1'b0;
            ptr_q      <= '0;
            raddr_q    <= '0;
            act_pipe_q <= '0;
            hs_pipe_q  <= '0;
            vs_pipe_q  <= '0;
            ld_pipe_q  <= '0;
            sh_q       <= '0;
            rgb_q      <= '0;
            hs_q       <= !SYNC_POL;
            vs_q       <= !SYNC_POL;
            fs_q       <= 1'b0;
        end else begin
            fs_q <= clken && wrap;
            if (clken) begin
                if (h_end) begin
                    hc_q <= '0;
                    vc_q <= v_end ? '0 : vc_q + VW'(1);
                end else begin
                    hc_q <= hc_q + HW'(1);
                end

                if (wrap) begin
                    mode_q <= mode;
                    ptr_q  <= base_addr;
                end else if (fetch_c) begin
                    raddr_q <= ptr_q;
                    ptr_q   <= ptr_q + ADDR_W'(1);
                end

                act_pipe_q[0] <= act_c;
                hs_pipe_q[0]  <= hs_c;
                vs_pipe_q[0]  <= vs_c;
                ld_pipe_q[0]  <= fetch_c;
                for (int i = RL; i > 0; i--) begin
                    act_pipe_q[i] <= act_pipe_q[i-1];
                    hs_pipe_q[i]  <= hs_pipe_q[i-1];
                    vs_pipe_q[i]  <= vs_pipe_q[i-1];
                end
                for (int i = RL - 1; i > 0; i--)
                    ld_pipe_q[i] <= ld_pipe_q[i-1];

                sh_q  <= sh_d;
                rgb_q <= rgb_d;
                hs_q  <= hs_pipe_q[RL] ? SYNC_POL : !SYNC_POL;
                vs_q  <= vs_pipe_q[RL] ? SYNC_POL : !SYNC_POL;
            end
        end
    end

    assign vram.vram_raddr = raddr_q;
    assign h_sync          = hs_q;
    assign v_sync          = vs_q;
    assign red             = rgb_q[11:8];
    assign green           = rgb_q[7:4];
    assign blue            = rgb_q[3:0];
    assign vblank          = (vc_q >= VW'(V_ACTIVE));
    assign frame_start     = fs_q;
endmodule

// File: tb/tb_vga_scanout.sv
// Scoreboard bench for vga_scanout on a shrunken 40x8 raster with a 2-cycle VRAM.
module tb_vga_scanout;
    localparam int HA = 32, HF = 2, HS = 4, HB = 2;
    localparam int VA = 4,  VF = 1, VS = 2, VB = 1;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int AW = 14;
    localparam int RL = 2;
    localparam int D  = RL + 2;

    logic clk = 1'b0, resetn = 1'b0, clken = 1'b0, mode = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic h_sync, v_sync, vblank, frame_start;
    logic [3:0] red, green, blue;

    vga_scanout_if #(.ADDR_W(AW)) vif();

    vga_scanout #(
        .ADDR_W(AW), .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .SYNC_POL(1'b0), .READ_LATENCY(RL)
    ) dut (
        .clk(clk), .resetn(resetn), .clken(clken), .mode(mode), .base_addr(base_addr),
        .vram(vif), .h_sync(h_sync), .v_sync(v_sync), .red(red), .green(green),
        .blue(blue), .vblank(vblank), .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    // VRAM: one register after the array read gives two clken edges of latency.
    logic [15:0] mem [0:(1<<AW)-1];
    logic [15:0] rd1 = '0;
    always @(posedge clk) if (clken) rd1 <= mem[vif.vram_raddr];
    assign vif.vram_rdata = rd1;

    typedef struct {
        logic [11:0] rgb;
        logic hs;
        logic vs;
        int hc;
        int vc;
    } pix_t;

    typedef struct {
        logic md;
        logic [15:0] w0, w1;
        int px [4];
        logic [11:0] rgb [4];
        int nfetch;
        int last;
    } vec_t;

    pix_t sb [$];
    pix_t last_exp, rst_pix;
    vec_t tbl [4];
    int n_chk = 0, n_fail = 0, cyc = 0;
    int m_hc, m_vc;
    logic m_mode, m_wrapped = 1'b0;
    logic [AW-1:0] m_base, m_ptr, m_raddr;
    logic [11:0] cap [0:HA-1];
    logic [AW-1:0] flog [0:127];
    logic [AW-1:0] fl_last = '0, raddr_prev = '0;
    int nflog = 0, raddr_chg = 0, raddr_chg_last = 0;
    int h_fall = -1, h_per = 0, h_low = 0, v_fall = -1, v_per = 0, v_low = 0;
    logic h_prev = 1'b1, v_prev = 1'b1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic vec_t mkv(logic md, logic [15:0] w0, logic [15:0] w1,
                                 int p0, int p1, int p2, int p3,
                                 logic [11:0] c0, logic [11:0] c1, logic [11:0] c2, logic [11:0] c3,
                                 int nf, int last);
        vec_t v;
        v.md = md; v.w0 = w0; v.w1 = w1;
        v.px[0] = p0; v.px[1] = p1; v.px[2] = p2; v.px[3] = p3;
        v.rgb[0] = c0; v.rgb[1] = c1; v.rgb[2] = c2; v.rgb[3] = c3;
        v.nfetch = nf; v.last = last;
        return v;
    endfunction

    // Expected pins for a raster position, from the linear pixel index of the frame.
    function automatic pix_t expect_pix(int hc, int vc);
        pix_t p;
        int idx, ppw;
        logic [15:0] w;
        logic [7:0] b;
        p.hc = hc; p.vc = vc;
        p.hs = !(hc >= HA + HF && hc < HA + HF + HS);
        p.vs = !(vc >= VA + VF && vc < VA + VF + VS);
        p.rgb = 12'h000;
        if (hc < HA && vc < VA) begin
            ppw = m_mode ? 2 : 16;
            idx = vc * HA + hc;
            w = mem[m_base + AW'(idx / ppw)];
            if (!m_mode) begin
                p.rgb = w[idx % ppw] ? 12'h000 : 12'hFFF;
            end else begin
                b = (idx % 2 == 0) ? w[15:8] : w[7:0];
                p.rgb = {b[5:4], b[5:4], b[3:2], b[3:2], b[1:0], b[1:0]};
            end
        end
        return p;
    endfunction

    task automatic model_reset();
        m_hc = HT - 1; m_vc = VT - 1;
        m_mode = 1'b0; m_base = '0; m_ptr = '0; m_raddr = '0;
        m_wrapped = 1'b0;
        sb.delete();
        last_exp = rst_pix;
        raddr_prev = '0; raddr_chg = 0; nflog = 0;
    endtask

    task automatic step(input logic ce);
        logic fetched;
        fetched = 1'b0;
        clken = ce;
        if (ce) begin
            sb.push_back(expect_pix(m_hc, m_vc));
            m_wrapped = 1'b0;
            if (m_hc < HA && m_vc < VA && (m_hc % (m_mode ? 2 : 16)) == 0) begin
                m_raddr = m_ptr;
                m_ptr = m_ptr + AW'(1);
                fetched = 1'b1;
            end
            if (m_hc == HT - 1) begin
                m_hc = 0;
                if (m_vc == VT - 1) begin
                    m_vc = 0; m_wrapped = 1'b1;
                    m_mode = mode; m_base = base_addr; m_ptr = base_addr;
                    fl_last = (nflog > 0) ? flog[nflog-1] : '0;
                    nflog = 0;
                end else begin
                    m_vc++;
                end
            end else begin
                m_hc++;
            end
        end
        @(posedge clk);
        #1;
        cyc++;
        if (ce) begin
            last_exp = (sb.size() >= D) ? sb.pop_front() : rst_pix;
            if (last_exp.vc == 0 && last_exp.hc >= 0 && last_exp.hc < HA)
                cap[last_exp.hc] = {red, green, blue};
        end
        chk("rgb", {red, green, blue}, last_exp.rgb);
        chk("h_sync", h_sync, last_exp.hs);
        chk("v_sync", v_sync, last_exp.vs);
        chk("vram_raddr", vif.vram_raddr, m_raddr);
        chk("frame_start", frame_start, ce && m_wrapped);
        chk("vblank", vblank, m_vc >= VA);
        if (fetched && nflog < 128) begin
            flog[nflog] = vif.vram_raddr;
            nflog++;
        end
        if (vif.vram_raddr !== raddr_prev) raddr_chg++;
        raddr_prev = vif.vram_raddr;
        if (ce && m_wrapped) begin
            raddr_chg_last = raddr_chg;
            raddr_chg = 0;
        end
        if (h_prev && !h_sync) begin
            if (h_fall >= 0) h_per = cyc - h_fall;
            h_fall = cyc;
        end
        if (!h_prev && h_sync && h_fall >= 0) h_low = cyc - h_fall;
        if (v_prev && !v_sync) begin
            if (v_fall >= 0) v_per = cyc - v_fall;
            v_fall = cyc;
        end
        if (!v_prev && v_sync && v_fall >= 0) v_low = cyc - v_fall;
        h_prev = h_sync;
        v_prev = v_sync;
    endtask

    task automatic run_to_wrap(input bit gated);
        bit done;
        done = 1'b0;
        for (int i = 0; i < 4 * HT * VT && !done; i++) begin
            step(1'b1);
            done = m_wrapped;
            if (gated) step(1'b0);
        end
        if (!done) chk("wrap_timeout", 0, 1);
    endtask

    task automatic run_to_line(input int v);
        bit done;
        done = 1'b0;
        for (int i = 0; i < 4 * HT * VT && !done; i++) begin
            step(1'b1);
            done = (m_vc == v);
        end
        if (!done) chk("line_timeout", 0, 1);
    endtask

    task automatic chk_reset_pins(input string nm);
        chk({nm, "_hs"}, h_sync, 1);
        chk({nm, "_vs"}, v_sync, 1);
        chk({nm, "_rgb"}, {red, green, blue}, 0);
        chk({nm, "_vblank"}, vblank, 1);
        chk({nm, "_raddr"}, vif.vram_raddr, 0);
        chk({nm, "_fs"}, frame_start, 0);
    endtask

    initial begin
        rst_pix.rgb = 12'h000; rst_pix.hs = 1'b1; rst_pix.vs = 1'b1;
        rst_pix.hc = -1; rst_pix.vc = -1;
        tbl[0] = mkv(1'b0, 16'h0001, 16'hFFFF, 0, 1, 15, 16, 12'h000, 12'hFFF, 12'hFFF, 12'h000, 8, 7);
        tbl[1] = mkv(1'b1, 16'h3F24, 16'h0030, 0, 1, 2, 3, 12'hFFF, 12'hA50, 12'h000, 12'hF00, 64, 63);
        tbl[2] = mkv(1'b0, 16'hAAAA, 16'h0000, 0, 1, 2, 17, 12'hFFF, 12'h000, 12'hFFF, 12'hFFF, 8, 7);
        tbl[3] = mkv(1'b1, 16'hC1C2, 16'h1B00, 0, 1, 2, 3, 12'h005, 12'h00A, 12'h5AF, 12'h000, 64, 63);
        for (int i = 0; i < (1 << AW); i++) mem[i] = 16'($urandom);
        for (int i = 0; i < HA; i++) cap[i] = '0;

        // Reset holds regardless of clken.
        repeat (2) @(posedge clk);
        #1 clken = 1'b1;
        repeat (2) @(posedge clk);
        #1 chk_reset_pins("reset");
        clken = 1'b0;
        model_reset();
        resetn = 1'b1;
        step(1'b1);
        chk("first_frame_start", frame_start, 1);
        step(1'b0);
        chk("frame_start_width", frame_start, 0);

        for (int r = 0; r < 4; r++) begin
            run_to_line(VA);
            mem[0] = tbl[r].w0;
            mem[1] = tbl[r].w1;
            mode = tbl[r].md;
            base_addr = '0;
            run_to_wrap(1'b0);
            if (r > 0) begin
                chk($sformatf("tbl%0d_prev_fetches", r), raddr_chg_last, tbl[r-1].nfetch);
                chk($sformatf("tbl%0d_prev_last", r), fl_last, tbl[r-1].last);
            end
            repeat (HT + D + 1) step(1'b1);
            for (int j = 0; j < 4; j++)
                chk($sformatf("tbl%0d_px%0d", r, tbl[r].px[j]), cap[tbl[r].px[j]], tbl[r].rgb[j]);
        end

        // Page flip: a mid-frame change only takes effect at the next wrap.
        mode = 1'b0;
        base_addr = '0;
        run_to_wrap(1'b0);
        chk("tbl3_fetches", raddr_chg_last, tbl[3].nfetch);
        chk("tbl3_last", fl_last, tbl[3].last);
        run_to_line(1);
        mode = 1'b1;
        base_addr = 14'h1000;
        run_to_wrap(1'b0);
        chk("flip_old_fetches", raddr_chg_last, 8);
        chk("flip_old_last", fl_last, 7);
        repeat (2 * HT) step(1'b1);
        chk("flip_first_fetch", flog[0], 14'h1000);
        run_to_wrap(1'b0);
        chk("flip_new_fetches", raddr_chg_last, 64);
        chk("flip_new_last", fl_last, 14'h1000 + 63);

        chk("h_period", h_per, HT);
        chk("h_low", h_low, HS);
        chk("v_period", v_per, HT * VT);
        chk("v_low", v_low, HT * VS);

        // Half-rate clken: periods double, pixels still tracked by the scoreboard.
        h_fall = -1; v_fall = -1;
        repeat (3) run_to_wrap(1'b1);
        chk("h_period_half", h_per, 2 * HT);
        chk("h_low_half", h_low, 2 * HS);
        chk("v_period_half", v_per, 2 * HT * VT);
        chk("v_low_half", v_low, 2 * HT * VS);

        // Address wrap at the top of VRAM.
        mode = 1'b0;
        base_addr = 14'h3FFF;
        run_to_wrap(1'b0);
        repeat (HT) step(1'b1);
        chk("wrap_fetch0", flog[0], 14'h3FFF);
        chk("wrap_fetch1", flog[1], 14'h0000);
        run_to_wrap(1'b0);

        // Reset asserted mid-frame, then a clean restart.
        run_to_line(2);
        resetn = 1'b0;
        #2 chk_reset_pins("midreset");
        @(posedge clk);
        #1;
        clken = 1'b0;
        model_reset();
        resetn = 1'b1;
        step(1'b1);
        chk("restart_frame_start", frame_start, 1);
        run_to_wrap(1'b0);
        run_to_wrap(1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
